// File: rtl/arbitro_rr_mux4_if.sv
// Bus bundle for the four-requester round-robin mux: requester words and requests in,
// grant/ack/select and the registered output word with its valid/ready handshake out.
interface arbitro_rr_mux4_if #(
    parameter int ANCHO = 8
);
    logic [3:0]       req;
    logic [ANCHO-1:0] D0;
    logic [ANCHO-1:0] D1;
    logic [ANCHO-1:0] D2;
    logic [ANCHO-1:0] D3;
    logic             q_ready;
    logic [3:0]       gnt;
    logic [3:0]       ack;
    logic [1:0]       sel;
    logic [ANCHO-1:0] Q;
    logic             q_valid;

    modport master (
        output req, D0, D1, D2, D3, q_ready,
        input  gnt, ack, sel, Q, q_valid
    );

    modport slave (
        input  req, D0, D1, D2, D3, q_ready,
        output gnt, ack, sel, Q, q_valid
    );
endinterface

// File: rtl/arbitro_rr_mux4.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with bounded bursts
// of MAX_RAFAGA beats and a single-entry registered output stage.
module arbitro_rr_mux4 #(
    parameter int ANCHO      = 8,
    parameter int MAX_RAFAGA = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    arbitro_rr_mux4_if.slave    bus
);

    localparam logic [3:0] LAST_BEAT = 4'(MAX_RAFAGA - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [3:0]       r_cnt;
    logic [3:0]       r_gnt;
    logic [ANCHO-1:0] r_q;
    logic             r_q_valid;

    logic             w_stage_free;
    logic             w_accept;
    logic             w_release;
    logic [1:0]       w_pick;
    logic [3:0]       w_ack;
    logic [ANCHO-1:0] w_data;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // First requester found scanning circularly upward from the priority pointer.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign w_pick       = rr_pick(bus.req, r_ptr);
    assign w_stage_free = !r_q_valid || bus.q_ready;
    assign w_accept     = (r_state == GRANT) && bus.req[r_sel] && w_stage_free;
    assign w_release    = (r_state == GRANT) &&
                          (!bus.req[r_sel] || (w_accept && (r_cnt == LAST_BEAT)));

    // Owner data mux driven by the registered select.
    always_comb begin
        w_data = bus.D0;
        case (r_sel)
            2'd0:    w_data = bus.D0;
            2'd1:    w_data = bus.D1;
            2'd2:    w_data = bus.D2;
            2'd3:    w_data = bus.D3;
            default: w_data = bus.D0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_state_nxt = GRANT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GRANT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-beat acknowledge; only ever raised toward the current owner.
    always_comb begin
        w_ack = 4'b0000;
        if (w_accept) begin
            w_ack = onehot(r_sel);
        end else begin
            w_ack = 4'b0000;
        end
    end

    // Grant, select, burst counter and priority pointer; sel deliberately holds on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt <= 4'b0000;
            r_sel <= 2'd0;
            r_cnt <= 4'd0;
            r_ptr <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_sel <= w_pick;
                        r_gnt <= onehot(w_pick);
                        r_cnt <= 4'd0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_gnt <= 4'b0000;
                        r_ptr <= r_sel + 2'd1;
                        r_cnt <= 4'd0;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_gnt <= 4'b0000;
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Output stage: refill on accept, otherwise drain when the consumer takes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else if (w_accept) begin
            r_q       <= w_data;
            r_q_valid <= 1'b1;
        end else if (r_q_valid && bus.q_ready) begin
            r_q_valid <= 1'b0;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.ack     = w_ack;
    assign bus.sel     = r_sel;
    assign bus.Q       = r_q;
    assign bus.q_valid = r_q_valid;

endmodule

// File: tb/tb_arbitro_rr_mux4.sv
// Bench for arbitro_rr_mux4: cycle table with a word scoreboard, plus hand sequences for
// asynchronous reset mid-burst and a single-beat-burst instance.
module tb_arbitro_rr_mux4;

    logic clk;
    logic rst_n;

    arbitro_rr_mux4_if #(.ANCHO(8)) bus4 ();
    arbitro_rr_mux4_if #(.ANCHO(8)) bus1 ();

    arbitro_rr_mux4 #(.ANCHO(8), .MAX_RAFAGA(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    arbitro_rr_mux4 #(.ANCHO(8), .MAX_RAFAGA(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       qr;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       qv;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    logic [7:0] base[4];
    int         k[4];
    int         n_checks;
    int         n_fail;
    logic       pop_due;
    logic [7:0] last_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic rst, input logic [3:0] req, input logic qr,
                                input logic [3:0] gnt, input logic [3:0] ack, input logic qv);
        vec_t v;
        v.rst = rst; v.req = req; v.qr = qr; v.gnt = gnt; v.ack = ack; v.qv = qv;
        vecs.push_back(v);
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        oh_idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) oh_idx = i;
        end
    endfunction

    task automatic drive4(input logic [3:0] req, input logic qr);
        bus4.req     = req;
        bus4.q_ready = qr;
        bus4.D0      = base[0] + 8'(k[0]);
        bus4.D1      = base[1] + 8'(k[1]);
        bus4.D2      = base[2] + 8'(k[2]);
        bus4.D3      = base[3] + 8'(k[3]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus4.req = 4'b0000;
        rst_n    = 1'b0;
        #1;
        chk("rst_gnt", 32'(bus4.gnt), 32'h0);
        chk("rst_qv",  32'(bus4.q_valid), 32'h0);
        chk("rst_q",   32'(bus4.Q), 32'h0);
        chk("rst_sel", 32'(bus4.sel), 32'h0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) k[i] = 0;
        sb.delete();
        pop_due = 1'b0;
        last_q  = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pop_due  = 1'b0;
        last_q   = 8'h00;
        base[0]  = 8'd10;
        base[1]  = 8'h20;
        base[2]  = 8'h55;
        base[3]  = 8'h30;
        for (int i = 0; i < 4; i++) k[i] = 0;
        rst_n        = 1'b0;
        bus1.req     = 4'b0000;
        bus1.q_ready = 1'b1;
        bus1.D0      = 8'h00;
        bus1.D1      = 8'hA1;
        bus1.D2      = 8'hB2;
        bus1.D3      = 8'h00;
        drive4(4'b0000, 1'b1);

        // Single requester 0: four beats, one idle cycle, regrant.
        add(1'b1, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b0);
        add(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1);
        add(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1);
        add(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1);
        add(1'b0, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b1);
        add(1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b0);
        add(1'b0, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1);
        // All four requesting: owners 0,1,2,3,0 with one idle cycle between.
        add(1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        for (int rnd = 0; rnd < 5; rnd++) begin
            for (int b = 0; b < 4; b++) begin
                add(1'b0, 4'b1111, 1'b1, 4'b0001 << (rnd % 4), 4'b0001 << (rnd % 4), (b != 0));
            end
            add(1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1);
        end
        // Back-pressure on owner 2 after its first beat.
        add(1'b1, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1);
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1);
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1);
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1);
        add(1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1);
        add(1'b0, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0);
        // Early drop by owner 1, then owner 3, then pointer wraps to owner 0.
        add(1'b1, 4'b1010, 1'b1, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b0);
        add(1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1);
        add(1'b0, 4'b1000, 1'b1, 4'b0010, 4'b0000, 1'b1);
        add(1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b0);
        add(1'b0, 4'b1001, 1'b1, 4'b1000, 4'b1000, 1'b0);
        add(1'b0, 4'b1001, 1'b1, 4'b1000, 4'b1000, 1'b1);
        add(1'b0, 4'b1001, 1'b1, 4'b1000, 4'b1000, 1'b1);
        add(1'b0, 4'b1001, 1'b1, 4'b1000, 4'b1000, 1'b1);
        add(1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b1);
        add(1'b0, 4'b1001, 1'b1, 4'b0001, 4'b0001, 1'b0);
        add(1'b0, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1);

        for (int r = 0; r < vecs.size(); r++) begin
            if (vecs[r].rst) do_reset();
            @(negedge clk);
            drive4(vecs[r].req, vecs[r].qr);
            #1;
            if (pop_due) begin
                if (sb.size() > 0) begin
                    last_q = sb.pop_front();
                end else begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end
                pop_due = 1'b0;
            end
            chk($sformatf("gnt[%0d]", r), 32'(bus4.gnt), 32'(vecs[r].gnt));
            chk($sformatf("ack[%0d]", r), 32'(bus4.ack), 32'(vecs[r].ack));
            chk($sformatf("qv[%0d]", r),  32'(bus4.q_valid), 32'(vecs[r].qv));
            if (vecs[r].qv) begin
                chk($sformatf("q[%0d]", r), 32'(bus4.Q), 32'(last_q));
            end
            if (vecs[r].ack != 4'b0000) begin
                sb.push_back(base[oh_idx(vecs[r].ack)] + 8'(k[oh_idx(vecs[r].ack)]));
                k[oh_idx(vecs[r].ack)]++;
                pop_due = 1'b1;
            end
        end

        // Asynchronous reset during owner 2's second beat.
        do_reset();
        @(negedge clk);
        bus4.req = 4'b0100; bus4.q_ready = 1'b1; bus4.D2 = 8'h55;
        #1 chk("mb_idle_gnt", 32'(bus4.gnt), 32'h0);
        @(negedge clk);
        #1 chk("mb_beat1_ack", 32'(bus4.ack), 32'h4);
        @(negedge clk);
        bus4.D2 = 8'h56;
        #1 chk("mb_beat2_ack", 32'(bus4.ack), 32'h4);
        chk("mb_beat2_q", 32'(bus4.Q), 32'h55);
        chk("mb_beat2_sel", 32'(bus4.sel), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        chk("mb_rst_gnt", 32'(bus4.gnt), 32'h0);
        chk("mb_rst_qv",  32'(bus4.q_valid), 32'h0);
        chk("mb_rst_q",   32'(bus4.Q), 32'h0);
        chk("mb_rst_sel", 32'(bus4.sel), 32'h0);
        chk("mb_rst_ack", 32'(bus4.ack), 32'h0);
        bus4.req = 4'b0101;
        @(negedge clk);
        #1 chk("mb_held_gnt", 32'(bus4.gnt), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("mb_regrant_gnt", 32'(bus4.gnt), 32'h1);
        chk("mb_regrant_sel", 32'(bus4.sel), 32'h0);

        // Single-beat bursts: requesters 1 and 2 alternate.
        do_reset();
        bus4.req = 4'b0000;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            bus1.req = 4'b0110;
            #1;
            if (c % 2 == 0) begin
                chk($sformatf("mr1_gnt[%0d]", c), 32'(bus1.gnt), 32'h0);
                chk($sformatf("mr1_ack[%0d]", c), 32'(bus1.ack), 32'h0);
                if (c >= 2) begin
                    chk($sformatf("mr1_qv[%0d]", c), 32'(bus1.q_valid), 32'h1);
                    chk($sformatf("mr1_q[%0d]", c), 32'(bus1.Q), (c % 4 == 2) ? 32'hA1 : 32'hB2);
                end
            end else begin
                chk($sformatf("mr1_gnt[%0d]", c), 32'(bus1.gnt), (c % 4 == 1) ? 32'h2 : 32'h4);
                chk($sformatf("mr1_ack[%0d]", c), 32'(bus1.ack), (c % 4 == 1) ? 32'h2 : 32'h4);
                chk($sformatf("mr1_qv[%0d]", c), 32'(bus1.q_valid), 32'h0);
            end
        end
        bus1.req = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
